// File: rtl/jpeg_bitstream_packer.sv
// JPEG entropy-coded bitstream packer.
// Collects right-aligned Huffman codes MSB-first into a 32-bit accumulator and
// emits bytes over a valid/ready handshake. On flush, a partial byte is padded
// with 1s and the accumulator is drained before a one-cycle flush_done pulse.
// Optional feature: define JPEG_BYTE_STUFF_EN to insert 0x00 after every 0xFF.
module jpeg_bitstream_packer #(
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        code_in_enable,
    input  logic [15:0] code_in,
    input  logic [4:0]  code_in_length,
    output logic        code_in_ready,
    input  logic        flush,
    output logic [7:0]  byte_out,
    output logic        byte_out_valid,
    input  logic        byte_out_ready,
    output logic        flush_done,
    output logic [15:0] byte_count
);

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StStuff = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    // Valid bits sit at the top of acc_q; bits_q counts them (0..32).
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [5:0]           bits_q, bits_d;
    logic [1:0]           state_q, state_d;
    logic                 ret_flush_q, ret_flush_d;
    logic [7:0]           byte_q, byte_d;
    logic                 valid_q, valid_d;
    logic                 done_q;
    logic [15:0]          cnt_q, cnt_d;

    logic [4:0]  len_eff;
    logic [15:0] code_masked;
    logic        slot_free;
    logic        accept;
    logic        extract;
    logic [5:0]  bits_base;
    logic [5:0]  ins_shift;
    logic [7:0]  acc_top;
    logic        load;
    logic [7:0]  load_byte;

    // Input conditioning and handshake qualifiers.
    always_comb begin
        len_eff       = (code_in_length > 5'd16) ? 5'd16 : code_in_length;
        code_masked   = code_in & ~(16'hFFFF << len_eff);
        slot_free     = !valid_q || byte_out_ready;
        code_in_ready = reset_n && (state_q == StRun) && (bits_q <= 6'd16);
        accept        = code_in_enable && code_in_ready;
        extract       = (bits_q >= 6'd8) && slot_free;
        bits_base     = extract ? (bits_q - 6'd8) : bits_q;
        // New code lands directly below the bits that remain after extraction.
        ins_shift     = 6'(ACC_WIDTH) - bits_base - {1'b0, len_eff};
        acc_top       = acc_q[ACC_WIDTH-1 -: 8];
    end

    // Next-state logic: accumulator, FSM and output slot.
    always_comb begin
        acc_d       = acc_q;
        bits_d      = bits_q;
        state_d     = state_q;
        ret_flush_d = ret_flush_q;
        byte_d      = byte_q;
        valid_d     = valid_q && !byte_out_ready;
        cnt_d       = cnt_q + {15'd0, valid_q && byte_out_ready};
        load        = 1'b0;
        load_byte   = 8'h00;

        case (state_q)
            StRun: begin
                if (extract) begin
                    load      = 1'b1;
                    load_byte = acc_top;
                    acc_d     = acc_q << 8;
                end
                bits_d = bits_base;
                if (accept) begin
                    acc_d  = acc_d | (ACC_WIDTH'(code_masked) << ins_shift);
                    bits_d = bits_base + {1'b0, len_eff};
                end
                if (flush) begin
                    state_d = StFlush;
                end
            end
            StStuff: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_byte = 8'h00;
                    state_d   = ret_flush_q ? StFlush : StRun;
                end
            end
            StFlush: begin
                if (bits_q >= 6'd8) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_byte = acc_top;
                        acc_d     = acc_q << 8;
                        bits_d    = bits_q - 6'd8;
                    end
                end else if (bits_q != 6'd0) begin
                    // Partial byte: bits below the valid ones are zero, fill with 1s.
                    if (slot_free) begin
                        load      = 1'b1;
                        load_byte = acc_top | (8'hFF >> bits_q[2:0]);
                        acc_d     = '0;
                        bits_d    = 6'd0;
                    end
                end else if (!valid_q) begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (load) begin
            byte_d  = load_byte;
            valid_d = 1'b1;
`ifdef JPEG_BYTE_STUFF_EN
            if (load_byte == 8'hFF) begin
                ret_flush_d = (state_d == StFlush);
                state_d     = StStuff;
            end
`endif
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_q       <= '0;
            bits_q      <= 6'd0;
            state_q     <= StRun;
            ret_flush_q <= 1'b0;
            byte_q      <= 8'h00;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            acc_q       <= acc_d;
            bits_q      <= bits_d;
            state_q     <= state_d;
            ret_flush_q <= ret_flush_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            done_q      <= (state_d == StDone);
            cnt_q       <= cnt_d;
        end
    end

    assign byte_out       = byte_q;
    assign byte_out_valid = valid_q;
    assign flush_done     = done_q;
    assign byte_count     = cnt_q;

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Bench for jpeg_bitstream_packer: a bit-queue model predicts the byte stream
// from accepted codes and flushes; a monitor checks it each cycle, and directed
// tests pin the model with literal byte sequences.
module tb_jpeg_bitstream_packer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        code_in_enable;
    logic [15:0] code_in;
    logic [4:0]  code_in_length;
    logic        code_in_ready;
    logic        flush;
    logic [7:0]  byte_out;
    logic        byte_out_valid;
    logic        byte_out_ready;
    logic        flush_done;
    logic [15:0] byte_count;

    always #5 clock = ~clock;

    jpeg_bitstream_packer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .code_in_enable (code_in_enable),
        .code_in        (code_in),
        .code_in_length (code_in_length),
        .code_in_ready  (code_in_ready),
        .flush          (flush),
        .byte_out       (byte_out),
        .byte_out_valid (byte_out_valid),
        .byte_out_ready (byte_out_ready),
        .flush_done     (flush_done),
        .byte_count     (byte_count)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       bitq[$];
    int         exp_count = 0;
    bit         flushing = 0;
    bit         prev_hold = 0;
    logic [7:0] prev_byte = 8'h00;
    bit         rand_mode = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void push_byte(input logic [7:0] b);
        exp_q.push_back(b);
`ifdef JPEG_BYTE_STUFF_EN
        if (b == 8'hFF) exp_q.push_back(8'h00);
`endif
    endfunction

    function automatic void pull_byte();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b = {b[6:0], bitq.pop_front()};
        push_byte(b);
    endfunction

    // Monitor and model: sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            bitq.delete();
            exp_count = 0;
            flushing  = 0;
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {31'd0, byte_out_valid}, 32'd1);
                check("hold_byte", {24'd0, byte_out}, {24'd0, prev_byte});
            end
            check("byte_count", {16'd0, byte_count}, exp_count & 32'hFFFF);
            if (flushing) check("ready_low_in_flush", {31'd0, code_in_ready}, 32'd0);
            else check("no_spurious_done", {31'd0, flush_done}, 32'd0);
            if (byte_out_valid && byte_out_ready) begin
                got_q.push_back(byte_out);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h expected none", byte_out);
                end else begin
                    check("byte_out", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
                end
                exp_count++;
            end
            prev_hold = byte_out_valid && !byte_out_ready;
            prev_byte = byte_out;
            if (flush_done && flushing) begin
                check("drained_at_done", exp_q.size(), 32'd0);
                flushing = 0;
            end
            if (code_in_enable && code_in_ready) begin
                int len;
                len = (code_in_length > 5'd16) ? 16 : int'(code_in_length);
                for (int i = len - 1; i >= 0; i--) bitq.push_back(code_in[i]);
                while (bitq.size() >= 8) pull_byte();
            end
            if (flush && !flushing) begin
                if (bitq.size() > 0) begin
                    while (bitq.size() < 8) bitq.push_back(1'b1);
                    pull_byte();
                end
                flushing = 1;
            end
        end
    end

    // Random backpressure during the mixed-stream phase.
    always @(posedge clock) begin
        #1;
        if (rand_mode) byte_out_ready = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        got_q.delete();
        reset_n = 1'b0;
        code_in_enable = 1'b0;
        flush = 1'b0;
        step();
        check("rst_byte_out", {24'd0, byte_out}, 32'h00);
        check("rst_valid", {31'd0, byte_out_valid}, 32'd0);
        check("rst_flush_done", {31'd0, flush_done}, 32'd0);
        check("rst_byte_count", {16'd0, byte_count}, 32'd0);
        check("rst_ready_low", {31'd0, code_in_ready}, 32'd0);
        reset_n = 1'b1;
        step();
        check("ready_after_rst", {31'd0, code_in_ready}, 32'd1);
    endtask

    task automatic send_code(input logic [15:0] c, input logic [4:0] l);
        bit ok;
        ok = 0;
        code_in = c;
        code_in_length = l;
        code_in_enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (code_in_ready) ok = 1;
            step();
            if (ok) break;
        end
        code_in_enable = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
    endtask

    task automatic do_flush_wait();
        bit seen;
        seen = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (flush_done) begin
                seen = 1;
                break;
            end
        end
        check("flush_done_seen", {31'd0, seen}, 32'd1);
        step();
        @(negedge clock);
        check("flush_done_one_cycle", {31'd0, flush_done}, 32'd0);
        check("ready_after_done", {31'd0, code_in_ready}, 32'd1);
    endtask

    task automatic check_got(input string name, input logic [7:0] e[$]);
        check({name, "_len"}, got_q.size(), e.size());
        for (int i = 0; i < e.size() && i < got_q.size(); i++)
            check(name, {24'd0, got_q[i]}, {24'd0, e[i]});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts;
        reset_n = 1'b0;
        code_in_enable = 1'b0;
        code_in = 16'h0;
        code_in_length = 5'd0;
        flush = 1'b0;
        byte_out_ready = 1'b1;
        step();

        // 3'b101 then 5'b11111 -> 0xBF
        do_reset();
        send_code(16'h0005, 5'd3);
        send_code(16'h001F, 5'd5);
        repeat (4) step();
        check_got("bf", '{8'hBF});
        check("bf_count", {16'd0, byte_count}, 32'd1);

        // 0xFF byte, with or without stuffing
        do_reset();
        send_code(16'h00FF, 5'd8);
        repeat (5) step();
`ifdef JPEG_BYTE_STUFF_EN
        check_got("ff", '{8'hFF, 8'h00});
        check("ff_count", {16'd0, byte_count}, 32'd2);
`else
        check_got("ff", '{8'hFF});
        check("ff_count", {16'd0, byte_count}, 32'd1);
`endif

        // 1'b0 then flush -> 0x7F
        do_reset();
        send_code(16'h0000, 5'd1);
        do_flush_wait();
        check_got("pad7f", '{8'h7F});

        // 0x1234 twice back-to-back
        do_reset();
        code_in = 16'h1234;
        code_in_length = 5'd16;
        code_in_enable = 1'b1;
        accepts = 0;
        for (int i = 0; i < 20 && accepts < 2; i++) begin
            @(negedge clock);
            if (code_in_ready) accepts++;
            step();
        end
        code_in_enable = 1'b0;
        check("two_accepts", accepts, 32'd2);
        @(negedge clock);
        check("ready_low_bc24", {31'd0, code_in_ready}, 32'd0);
        repeat (6) step();
        check_got("h1234", '{8'h12, 8'h34, 8'h12, 8'h34});

        // Backpressure: byte held for 3 cycles
        do_reset();
        byte_out_ready = 1'b0;
        send_code(16'h00AB, 5'd8);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_valid", {31'd0, byte_out_valid}, 32'd1);
            check("stall_byte", {24'd0, byte_out}, 32'hAB);
            check("stall_count", {16'd0, byte_count}, 32'd0);
            step();
        end
        byte_out_ready = 1'b1;
        repeat (3) step();
        check_got("stall", '{8'hAB});
        check("stall_count_end", {16'd0, byte_count}, 32'd1);

        // Reset with 12 bits pending, then flush emits nothing
        do_reset();
        byte_out_ready = 1'b0;
        send_code(16'h0ABC, 5'd12);
        repeat (2) step();
        do_reset();
        byte_out_ready = 1'b1;
        do_flush_wait();
        check_got("rst_flush", '{});
        check("rst_flush_count", {16'd0, byte_count}, 32'd0);

        // Length 0 ignored, length 31 clamped to 16
        do_reset();
        send_code(16'hFFFF, 5'd0);
        send_code(16'h00A5, 5'd31);
        repeat (4) step();
        check_got("clamp", '{8'h00, 8'hA5});

        // Single 1 bit flushed pads to 0xFF
        do_reset();
        send_code(16'h0001, 5'd1);
        do_flush_wait();
`ifdef JPEG_BYTE_STUFF_EN
        check_got("padff", '{8'hFF, 8'h00});
`else
        check_got("padff", '{8'hFF});
`endif

        // Mixed stream under random backpressure, checked by the model
        do_reset();
        rand_mode = 1;
        for (int i = 0; i < 60; i++) begin
            logic [15:0] c;
            c = (i % 5 == 0) ? 16'hFFFF : 16'($urandom());
            send_code(c, 5'($urandom_range(0, 20)));
        end
        rand_mode = 0;
        step();
        byte_out_ready = 1'b1;
        repeat (12) step();
        do_flush_wait();
        send_code(16'h0003, 5'd2);
        do_flush_wait();
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jpeg_bitstream_packer.md
JPEG_BITSTREAM_PACKER -- requirements
Module: jpeg_bitstream_packer

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32, bit-accumulator width (fixed at 32; other values unsupported).
REQ-002 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port code_in_enable  input  1  Huffman code valid this cycle.
REQ-005 SHALL have port code_in  input  16  code value, right-aligned; bits above code_in_length ignored.
REQ-006 SHALL have port code_in_length  input  5  code length in bits, 0..16.
REQ-007 SHALL have port code_in_ready  output  1  packer accepts a code this cycle.
REQ-008 SHALL have port flush  input  1  end-of-scan request: pad and drain.
REQ-009 SHALL have port byte_out  output  8  packed JPEG byte.
REQ-010 SHALL have port byte_out_valid  output  1  byte_out holds a valid byte.
REQ-011 SHALL have port byte_out_ready  input  1  downstream consumes byte_out this cycle.
REQ-012 SHALL have port flush_done  output  1  one-cycle pulse when the flush has completed.
REQ-013 SHALL have port byte_count  output  16  count of bytes transferred, including stuffed bytes.

Function
REQ-014 SHALL accept a code on any cycle where code_in_enable and code_in_ready are both high.
REQ-015 SHALL append accepted bits MSB-first (bit code_in_length-1 first) below the bits already held in the accumulator.
REQ-016 SHALL drive code_in_ready high only when state is RUN and bit_count <= 16.
REQ-017 SHALL accept a code with code_in_length 0 and leave the accumulator unchanged; lengths 17..31 SHALL be treated as 16.
REQ-018 SHALL load the top 8 accumulator bits into byte_out when bit_count >= 8 and the output slot is free (byte_out_valid low, or byte_out_ready high).
REQ-019 SHALL, when a code is accepted and a byte is extracted in the same cycle, set the next bit_count to bit_count + len - 8.
REQ-020 SHALL present the first byte at the earliest one cycle after the accepting edge.
REQ-021 SHALL hold byte_out and byte_out_valid stable while byte_out_valid is high and byte_out_ready is low.
REQ-022 SHALL increment byte_count (wrapping at 16 bits) on every cycle where byte_out_valid and byte_out_ready are both high.
REQ-023 SHALL implement the states RUN, STUFF, FLUSH and DONE; reset enters RUN.
REQ-024 SHALL transition RUN->STUFF when a 0xFF byte is loaded (stuffing enabled); STUFF SHALL load 0x00 when the slot is free, then return to RUN or FLUSH, whichever was pending.
REQ-025 SHALL, when flush is high in RUN, accept any same-cycle valid code first and then enter FLUSH; flush SHALL be ignored in any other state.
REQ-026 SHALL, in FLUSH, pad a partial byte (1..7 bits) with 1s to 8 bits, emit it (with stuffing if it is 0xFF), and enter DONE once the accumulator is empty and byte_out_valid is low.
REQ-027 SHALL, when flush arrives with bit_count 0 and no pending byte, reach DONE without emitting a byte.
REQ-028 SHALL pulse flush_done for exactly one cycle in DONE and then return to RUN with byte_count preserved.
REQ-029 SHALL hold code_in_ready low in the STUFF, FLUSH and DONE states.

Reset
REQ-030 SHALL, when reset_n is low at a clock edge, clear the accumulator, bit_count, byte_out (0x00), byte_out_valid, flush_done and byte_count (0), and set the state to RUN, including mid-operation.
REQ-031 SHALL drive code_in_ready low during the reset cycle and high on the first cycle after reset.

Configuration
REQ-032 SHALL, when JPEG_BYTE_STUFF_EN is defined, insert 0x00 after every emitted 0xFF, including a padded flush byte.
REQ-033 SHALL, when JPEG_BYTE_STUFF_EN is undefined, never enter STUFF and emit 0xFF with no following byte.

Verification
REQ-034 SHALL verify: code 3'b101 then 5'b11111, byte_out_ready=1 -> single byte 0xBF; byte_count=1.
REQ-035 SHALL verify: code 8'hFF len 8 with JPEG_BYTE_STUFF_EN -> bytes 0xFF,0x00 and byte_count=2; without the macro -> 0xFF only and byte_count=1.
REQ-036 SHALL verify: code 1'b0 len 1 then flush -> byte 0x7F, then flush_done pulses one cycle, then code_in_ready returns high.
REQ-037 SHALL verify: codes 16'h1234 len 16 twice back-to-back -> bytes 0x12,0x34,0x12,0x34, with code_in_ready low whenever bit_count > 16.
REQ-038 SHALL verify: byte_out_ready held low 3 cycles with a byte pending -> byte_out stable and valid throughout, and no byte_count increment.
REQ-039 SHALL verify: reset_n low with 12 bits pending -> all outputs at reset values next cycle, and a flush then gives flush_done with no byte emitted.
